// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline control path: scheduler state and the
// per-stage stall/flush bundle consumed by the datapath.
package pipeline_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } ctrl_state_t;

   typedef struct packed {
      logic stall_f;
      logic stall_d;
      logic stall_e;
      logic flush_d;
      logic flush_e;
      logic flush_m;
   } stall_flush_t;

   localparam stall_flush_t SF_NONE = '0;

   // Hold the front end and bubble M while the mul/div occupies E.
   localparam stall_flush_t SF_MD_HOLD = '{
      stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
      flush_d: 1'b0, flush_e: 1'b0, flush_m: 1'b1
   };

   localparam stall_flush_t SF_BRANCH = '{
      stall_f: 1'b0, stall_d: 1'b0, stall_e: 1'b0,
      flush_d: 1'b1, flush_e: 1'b1, flush_m: 1'b0
   };

   // Load-use bubble; the watchdog abort reuses it to kill the hung op in E.
   localparam stall_flush_t SF_LOAD_USE = '{
      stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b0,
      flush_d: 1'b0, flush_e: 1'b1, flush_m: 1'b0
   };

endpackage

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler: merges mul/div, branch and load-use requests,
// owns the mul/div handshake, its watchdog and a stall-cycle counter.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = 64,
   parameter int unsigned TO_W       = 7,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             LoadUseE,
   input  logic             PCSrcE,
   input  logic             MulDivE,
   input  logic             md_done,
   output logic             md_start,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushM,
   output logic             md_busy,
   output logic             md_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MD_TIMEOUT - 1);

   if (MD_TIMEOUT < 2) begin : g_bad_timeout
      $error("pipeline_ctrl: MD_TIMEOUT must be at least 2");
   end
   if ((64'd1 << TO_W) <= 64'(MD_TIMEOUT)) begin : g_bad_to_w
      $error("pipeline_ctrl: TO_W too narrow for MD_TIMEOUT");
   end

   ctrl_state_t     state, state_nxt;
   logic [TO_W-1:0] wait_cnt, wait_nxt;
   logic            err_set;
   logic            start_c;
   stall_flush_t    ctl;

   // Next-state and control decode; reset forces every control output low.
   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      err_set   = 1'b0;
      start_c   = 1'b0;
      ctl       = SF_NONE;
      if (!reset) begin
         unique case (state)
            RUN: begin
               if (MulDivE) begin
                  start_c   = 1'b1;
                  ctl       = SF_MD_HOLD;
                  state_nxt = MD_WAIT;
                  wait_nxt  = '0;
               end else if (PCSrcE) begin
                  ctl = SF_BRANCH;
               end else if (LoadUseE) begin
                  ctl = SF_LOAD_USE;
               end
            end
            MD_WAIT: begin
               if (md_done) begin
                  state_nxt = RUN;
               end else if (wait_cnt == WAIT_LAST) begin
                  ctl       = SF_LOAD_USE;
                  err_set   = 1'b1;
                  state_nxt = RUN;
               end else begin
                  ctl      = SF_MD_HOLD;
                  wait_nxt = wait_cnt + TO_W'(1);
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // State, watchdog counter, sticky error and saturating stall counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         wait_cnt  <= '0;
         md_err    <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (err_set) begin
            md_err <= 1'b1;
         end
         if (ctl.stall_f && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   assign md_start = start_c;
   assign StallF   = ctl.stall_f;
   assign StallD   = ctl.stall_d;
   assign StallE   = ctl.stall_e;
   assign FlushD   = ctl.flush_d;
   assign FlushE   = ctl.flush_e;
   assign FlushM   = ctl.flush_m;
   assign md_busy  = !reset && (state == MD_WAIT);

   // A legal decoder never presents a mul/div together with a branch or load-use.
   a_md_exclusive: assert property (@(posedge clk) disable iff (reset)
      (state == RUN) |-> !(MulDivE && (PCSrcE || LoadUseE)))
      else $error("pipeline_ctrl: MulDivE together with PCSrcE/LoadUseE");

endmodule
